// File: rtl/id_ex_reg_pkg.sv
// Shared ARM pipeline definitions: ALU command encodings, ctrl bit positions, field widths.
package id_ex_reg_pkg;

  localparam int ExeCmdW  = 4;
  localparam int CtrlW    = 5;
  localparam int ShiftOpW = 12;
  localparam int SImm24W  = 24;
  localparam int StatusW  = 4;

  // Bit positions inside ctrl_in = {wb_en, mem_r_en, mem_w_en, b, s}
  localparam int CtrlWbEn   = 4;
  localparam int CtrlMemREn = 3;
  localparam int CtrlMemWEn = 2;
  localparam int CtrlB      = 1;
  localparam int CtrlS      = 0;

  // Several mnemonics share an encoding (CMP/SUB, TST/AND, LDR/STR/ADD), so these are plain constants
  localparam logic [ExeCmdW-1:0] ExeNop = 4'b0000;
  localparam logic [ExeCmdW-1:0] ExeMov = 4'b0001;
  localparam logic [ExeCmdW-1:0] ExeMvn = 4'b1001;
  localparam logic [ExeCmdW-1:0] ExeAdd = 4'b0010;
  localparam logic [ExeCmdW-1:0] ExeAdc = 4'b0011;
  localparam logic [ExeCmdW-1:0] ExeSub = 4'b0100;
  localparam logic [ExeCmdW-1:0] ExeSbc = 4'b0101;
  localparam logic [ExeCmdW-1:0] ExeAnd = 4'b0110;
  localparam logic [ExeCmdW-1:0] ExeOrr = 4'b0111;
  localparam logic [ExeCmdW-1:0] ExeEor = 4'b1000;
  localparam logic [ExeCmdW-1:0] ExeCmp = 4'b0100;
  localparam logic [ExeCmdW-1:0] ExeTst = 4'b0110;
  localparam logic [ExeCmdW-1:0] ExeLdr = 4'b0010;
  localparam logic [ExeCmdW-1:0] ExeStr = 4'b0010;

  // An invalid slot must carry no side effects into EX.
  function automatic logic [CtrlW-1:0] slotCtrl(input logic vld, input logic [CtrlW-1:0] ctrl);
    return vld ? ctrl : '0;
  endfunction

  function automatic logic [ExeCmdW-1:0] slotCmd(input logic vld, input logic [ExeCmdW-1:0] cmd);
    return vld ? cmd : ExeNop;
  endfunction

endpackage

// File: rtl/id_ex_reg_pipe_reg.sv
// Generic pipeline field register: 1-cycle latency; clr beats en, en low holds (stall).
module pipe_reg #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: 1-cycle latency; freeze holds everything, flush (wins over freeze) loads a bubble.
// Optional status {N,Z,C,V} pass-through under ID_EX_STATUS_EN; status survives flush bubbles.
module id_ex_reg
  import id_ex_reg_pkg::*;
#(
  parameter  int WordLen   = 32,
  parameter  int WordCount = 16,
  localparam int RA        = $clog2(WordCount)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                freeze,
  input  logic                flush,
  input  logic                valid_in,
  input  logic [WordLen-1:0]  pc_in,
  input  logic [WordLen-1:0]  val_rn_in,
  input  logic [WordLen-1:0]  val_rm_in,
  input  logic [RA-1:0]       dest_in,
  input  logic [RA-1:0]       src1_in,
  input  logic [RA-1:0]       src2_in,
  input  logic [ExeCmdW-1:0]  exe_cmd_in,
  input  logic [CtrlW-1:0]    ctrl_in,
  input  logic                imm_in,
  input  logic [ShiftOpW-1:0] shift_operand_in,
  input  logic [SImm24W-1:0]  signed_imm_24_in,
`ifdef ID_EX_STATUS_EN
  input  logic [StatusW-1:0]  status_in,
  output logic [StatusW-1:0]  status_out,
`endif
  output logic                valid_out,
  output logic [WordLen-1:0]  pc_out,
  output logic [WordLen-1:0]  val_rn_out,
  output logic [WordLen-1:0]  val_rm_out,
  output logic [RA-1:0]       dest_out,
  output logic [RA-1:0]       src1_out,
  output logic [RA-1:0]       src2_out,
  output logic [ExeCmdW-1:0]  exe_cmd_out,
  output logic [CtrlW-1:0]    ctrl_out,
  output logic                imm_out,
  output logic [ShiftOpW-1:0] shift_operand_out,
  output logic [SImm24W-1:0]  signed_imm_24_out
);

  logic capEn;
  logic [CtrlW-1:0]   ctrlD;
  logic [ExeCmdW-1:0] cmdD;

  assign capEn = ~freeze;
  assign ctrlD = slotCtrl(valid_in, ctrl_in);
  assign cmdD  = slotCmd(valid_in, exe_cmd_in);

  pipe_reg #(.Width(1)) uValid (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(valid_in), .q(valid_out));
  pipe_reg #(.Width(WordLen)) uPc (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(pc_in), .q(pc_out));
  pipe_reg #(.Width(WordLen)) uRn (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(val_rn_in), .q(val_rn_out));
  pipe_reg #(.Width(WordLen)) uRm (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(val_rm_in), .q(val_rm_out));
  pipe_reg #(.Width(RA)) uDest (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(dest_in), .q(dest_out));
  pipe_reg #(.Width(RA)) uSrc1 (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(src1_in), .q(src1_out));
  pipe_reg #(.Width(RA)) uSrc2 (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(src2_in), .q(src2_out));
  pipe_reg #(.Width(ExeCmdW)) uCmd (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(cmdD), .q(exe_cmd_out));
  pipe_reg #(.Width(CtrlW)) uCtrl (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(ctrlD), .q(ctrl_out));
  pipe_reg #(.Width(1)) uImm (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(imm_in), .q(imm_out));
  pipe_reg #(.Width(ShiftOpW)) uShift (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(shift_operand_in), .q(shift_operand_out));
  pipe_reg #(.Width(SImm24W)) uSImm (.clk(clk), .rst(rst), .en(capEn), .clr(flush), .d(signed_imm_24_in), .q(signed_imm_24_out));

`ifdef ID_EX_STATUS_EN
  logic statusEn;
  // Flags belong to the last real instruction, so a bubble leaves them in place.
  assign statusEn = ~freeze & ~flush;
  pipe_reg #(.Width(StatusW)) uStatus (.clk(clk), .rst(rst), .en(statusEn), .clr(1'b0), .d(status_in), .q(status_out));
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg (status path exercised when ID_EX_STATUS_EN is defined).
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, valid_in, imm_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in;
  logic [3:0]  dest_in, src1_in, src2_in, exe_cmd_in;
  logic [4:0]  ctrl_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic        valid_out, imm_out;
  logic [31:0] pc_out, val_rn_out, val_rm_out;
  logic [3:0]  dest_out, src1_out, src2_out, exe_cmd_out;
  logic [4:0]  ctrl_out;
  logic [11:0] shift_operand_out;
  logic [23:0] signed_imm_24_out;
`ifdef ID_EX_STATUS_EN
  logic [3:0]  status_in, status_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.WordLen(32), .WordCount(16)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_in(valid_in),
    .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
    .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
    .exe_cmd_in(exe_cmd_in), .ctrl_in(ctrl_in), .imm_in(imm_in),
    .shift_operand_in(shift_operand_in), .signed_imm_24_in(signed_imm_24_in),
`ifdef ID_EX_STATUS_EN
    .status_in(status_in), .status_out(status_out),
`endif
    .valid_out(valid_out), .pc_out(pc_out), .val_rn_out(val_rn_out), .val_rm_out(val_rm_out),
    .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .exe_cmd_out(exe_cmd_out), .ctrl_out(ctrl_out), .imm_out(imm_out),
    .shift_operand_out(shift_operand_out), .signed_imm_24_out(signed_imm_24_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; valid_in = 1'b0; imm_in = 1'b0;
    pc_in = '0; val_rn_in = '0; val_rm_in = '0; dest_in = '0; src1_in = '0; src2_in = '0;
    exe_cmd_in = '0; ctrl_in = '0; shift_operand_in = '0; signed_imm_24_in = '0;
`ifdef ID_EX_STATUS_EN
    status_in = '0;
`endif
    #2;
    check("reset_valid", valid_out, 0);
    check("reset_pc", pc_out, 0);
    check("reset_ctrl", ctrl_out, 0);
    step();

    // Basic capture
    rst = 1'b1; valid_in = 1'b1; pc_in = 32'h4; val_rn_in = 32'h5; val_rm_in = 32'h7;
    dest_in = 4'd3; src1_in = 4'd1; src2_in = 4'd2; exe_cmd_in = 4'd2; ctrl_in = 5'b10001;
    imm_in = 1'b1; shift_operand_in = 12'habc; signed_imm_24_in = 24'h123456;
    step();
    check("cap_valid", valid_out, 1);
    check("cap_pc", pc_out, 32'h4);
    check("cap_rn", val_rn_out, 32'h5);
    check("cap_rm", val_rm_out, 32'h7);
    check("cap_dest", dest_out, 3);
    check("cap_src", {src1_out, src2_out}, 8'h12);
    check("cap_cmd", exe_cmd_out, 2);
    check("cap_ctrl", ctrl_out, 5'b10001);
    check("cap_imm", imm_out, 1);
    check("cap_shift", shift_operand_out, 12'habc);
    check("cap_simm", signed_imm_24_out, 24'h123456);

    // Freeze holds for three cycles while inputs move
    freeze = 1'b1; pc_in = 32'h8; ctrl_in = 5'b01000; dest_in = 4'd9;
    step(); check("frz1_pc", pc_out, 32'h4);
    step(); check("frz2_pc", pc_out, 32'h4);
    step(); check("frz3_pc", pc_out, 32'h4);
    check("frz_ctrl", ctrl_out, 5'b10001);
    check("frz_dest", dest_out, 3);
    freeze = 1'b0;
    step();
    check("unfrz_pc", pc_out, 32'h8);
    check("unfrz_ctrl", ctrl_out, 5'b01000);
    pc_in = 32'hc;
    step();
    check("next_pc", pc_out, 32'hc);

    // Flush beats freeze
    flush = 1'b1; freeze = 1'b1; ctrl_in = 5'b11111; exe_cmd_in = 4'd5; pc_in = 32'h10;
    step();
    check("flush_valid", valid_out, 0);
    check("flush_ctrl", ctrl_out, 0);
    check("flush_cmd", exe_cmd_out, 0);
    check("flush_pc", pc_out, 0);
    check("flush_dest", dest_out, 0);
    flush = 1'b0; freeze = 1'b0;

    // Invalid slot suppresses side effects, data still flows
    valid_in = 1'b0; ctrl_in = 5'b10100; exe_cmd_in = 4'd2; pc_in = 32'h14;
    step();
    check("inv_ctrl", ctrl_out, 0);
    check("inv_cmd", exe_cmd_out, 0);
    check("inv_valid", valid_out, 0);
    check("inv_pc", pc_out, 32'h14);

    // Destination 0 does not gate writeback
    valid_in = 1'b1; dest_in = 4'd0; ctrl_in = 5'b10000; exe_cmd_in = 4'd1;
    step();
    check("dest0_ctrl", ctrl_out, 5'b10000);
    check("dest0_cmd", exe_cmd_out, 1);

    // Asynchronous reset during freeze
    pc_in = 32'h20; ctrl_in = 5'b10001; dest_in = 4'd7;
    step();
    check("pre_rst_pc", pc_out, 32'h20);
    freeze = 1'b1;
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_pc", pc_out, 0);
    check("arst_valid", valid_out, 0);
    check("arst_ctrl", ctrl_out, 0);
    check("arst_dest", dest_out, 0);
    freeze = 1'b0; flush = 1'b0;
    step();
    check("rst_hold_pc", pc_out, 0);
    check("rst_hold_valid", valid_out, 0);
    rst = 1'b1;
    step();
    check("post_rst_pc", pc_out, 32'h20);
    check("post_rst_valid", valid_out, 1);

`ifdef ID_EX_STATUS_EN
    status_in = 4'b1010;
    step();
    check("status_cap", status_out, 4'b1010);
    flush = 1'b1; status_in = 4'b0101;
    step();
    check("status_flush", status_out, 4'b1010);
    check("status_flush_valid", valid_out, 0);
    flush = 1'b0; freeze = 1'b1;
    step();
    check("status_freeze", status_out, 4'b1010);
    freeze = 1'b0;
    step();
    check("status_resume", status_out, 4'b0101);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
